// File: rtl/iigs_pkg.sv
// Shared definitions for the sound GLU: register offsets, SOUNDCTL bit positions,
// the transfer FSM states and the captured-transfer record.
package iigs_pkg;

  localparam logic [1:0] SND_CTL  = 2'd0;
  localparam logic [1:0] SND_DATA = 2'd1;
  localparam logic [1:0] SND_ADRL = 2'd2;
  localparam logic [1:0] SND_ADRH = 2'd3;

  localparam int CTL_BUSY    = 7;
  localparam int CTL_RAM     = 6;
  localparam int CTL_AUTOINC = 5;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    WAIT_R,
    WAIT_D
  } glu_state_t;

  // Writable SOUNDCTL fields; bit 7 is derived and bit 4 is reserved, so neither is stored.
  typedef struct packed {
    logic       ram;
    logic       autoinc;
    logic [3:0] volume;
  } glu_ctl_t;

  typedef struct packed {
    logic        ram;
    logic        write;
    logic [15:0] addr;
    logic [7:0]  data;
  } xfer_t;

endpackage

// File: rtl/sound_glu_if.sv
// CPU-side IO strobe bus as seen by the sound GLU (same contract as adb/prtc/iwm).
interface sound_glu_if;

  logic [7:0] addr;
  logic       rw;
  logic [7:0] din;
  logic       strobe;
  logic [7:0] dout;

  modport master (output addr, rw, din, strobe, input dout);
  modport slave  (input addr, rw, din, strobe, output dout);

endinterface

// File: rtl/glu_xfer.sv
// Transfer engine of the sound GLU: holds the captured target/address/data and
// sequences one RAM or DOC access per accepted SOUNDDATA strobe.
module glu_xfer import iigs_pkg::*; #(
  parameter int RAM_AW = 16
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              cen,
  input  logic              start,
  input  xfer_t             xfer_in,
  output logic              busy,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [7:0]        ram_wdata,
  output logic              ram_we,
  output logic              ram_req,
  input  logic              ram_ack,
  input  logic [7:0]        ram_rdata,
  output logic [7:0]        doc_addr,
  output logic [7:0]        doc_wdata,
  output logic              doc_we,
  output logic              doc_strobe,
  input  logic [7:0]        doc_rdata,
  output logic              latch_en,
  output logic [7:0]        latch_data
);

  glu_state_t state, state_nxt;
  xfer_t      xfer;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      xfer  <= '0;
    end else begin
      state <= state_nxt;
      if (start) xfer <= xfer_in;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, otherwise a latch is inferred.
    state_nxt  = state;
    doc_strobe = 1'b0;
    latch_en   = 1'b0;
    latch_data = 8'h00;
    case (state)
      IDLE:   if (start) state_nxt = BUSY;
      BUSY: begin
        if (cen) begin
          if (xfer.ram) begin
            state_nxt = WAIT_R;
          end else begin
            doc_strobe = 1'b1;
            state_nxt  = WAIT_D;
          end
        end
      end
      // ram_ack completes the access regardless of cen.
      WAIT_R: begin
        if (ram_ack) begin
          latch_en   = !xfer.write;
          latch_data = ram_rdata;
          state_nxt  = IDLE;
        end
      end
      WAIT_D: begin
        latch_en   = !xfer.write;
        latch_data = doc_rdata;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy      = (state != IDLE);
  assign ram_req   = (state == WAIT_R);
  assign ram_we    = ram_req && xfer.write;
  assign ram_addr  = xfer.addr[RAM_AW-1:0];
  assign ram_wdata = xfer.data;
  assign doc_we    = doc_strobe && xfer.write;
  assign doc_addr  = xfer.addr[7:0];
  assign doc_wdata = xfer.data;

endmodule

// File: rtl/sound_glu.sv
// Sound GLU responder for $C03C-$C03F bridging CPU accesses to the DOC or sound RAM.
// Build option: SOUND_GLU_BUSY_EN makes SOUNDCTL[7] report busy; otherwise it reads 0.
module sound_glu import iigs_pkg::*; #(
  parameter logic [7:0] BASE   = 8'h3C,
  parameter int         RAM_AW = 16
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              cen,
  sound_glu_if.slave        io,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [7:0]        ram_wdata,
  output logic              ram_we,
  output logic              ram_req,
  input  logic              ram_ack,
  input  logic [7:0]        ram_rdata,
  output logic [7:0]        doc_addr,
  output logic [7:0]        doc_wdata,
  output logic              doc_we,
  output logic              doc_strobe,
  input  logic [7:0]        doc_rdata,
  output logic [3:0]        volume
);

  glu_ctl_t    ctl;
  logic [15:0] adr;
  logic [7:0]  data_latch;
  logic        busy, busy_bit;
  logic        sel, accept;
  logic        latch_en;
  logic [7:0]  latch_data;
  logic [7:0]  ctl_rd;
  xfer_t       xfer_in;

  assign sel    = io.strobe && (io.addr[7:2] == BASE[7:2]);
  // A SOUNDDATA access while busy (including the ack cycle) is neither queued nor counted.
  assign accept = sel && (io.addr[1:0] == SND_DATA) && !busy;

  assign xfer_in = '{ram: ctl.ram, write: !io.rw, addr: adr, data: io.din};

`ifdef SOUND_GLU_BUSY_EN
  assign busy_bit = busy;
`else
  assign busy_bit = 1'b0;
`endif

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      ctl        <= '0;
      adr        <= 16'h0000;
      data_latch <= 8'h00;
    end else begin
      if (accept && ctl.autoinc) adr <= adr + 16'd1;
      if (sel && !io.rw) begin
        case (io.addr[1:0])
          SND_CTL:  ctl <= '{ram: io.din[CTL_RAM], autoinc: io.din[CTL_AUTOINC], volume: io.din[3:0]};
          SND_ADRL: adr[7:0]  <= io.din;
          SND_ADRH: adr[15:8] <= io.din;
          default:  ;
        endcase
      end
      if (latch_en) data_latch <= latch_data;
    end
  end

  always_comb begin
    ctl_rd              = 8'h00;
    ctl_rd[CTL_BUSY]    = busy_bit;
    ctl_rd[CTL_RAM]     = ctl.ram;
    ctl_rd[CTL_AUTOINC] = ctl.autoinc;
    ctl_rd[3:0]         = ctl.volume;
  end

  always_comb begin
    io.dout = 8'h00;
    if (sel) begin
      case (io.addr[1:0])
        SND_CTL:  io.dout = ctl_rd;
        SND_DATA: io.dout = data_latch;
        SND_ADRL: io.dout = adr[7:0];
        SND_ADRH: io.dout = adr[15:8];
        default:  io.dout = 8'h00;
      endcase
    end
  end

  assign volume = ctl.volume;

  glu_xfer #(.RAM_AW(RAM_AW)) u_xfer (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .cen        (cen),
    .start      (accept),
    .xfer_in    (xfer_in),
    .busy       (busy),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_we     (ram_we),
    .ram_req    (ram_req),
    .ram_ack    (ram_ack),
    .ram_rdata  (ram_rdata),
    .doc_addr   (doc_addr),
    .doc_wdata  (doc_wdata),
    .doc_we     (doc_we),
    .doc_strobe (doc_strobe),
    .doc_rdata  (doc_rdata),
    .latch_en   (latch_en),
    .latch_data (latch_data)
  );

endmodule

// File: tb/tb_sound_glu.sv
// Bench for sound_glu: directed scenarios with literal expectations, then random traffic
// compared every cycle against a transaction-level model of the register/transfer rules.
module tb_sound_glu;

`ifdef SOUND_GLU_BUSY_EN
  localparam bit BUSY_BIT_EN = 1'b1;
`else
  localparam bit BUSY_BIT_EN = 1'b0;
`endif

  logic        clk_sys = 1'b0;
  logic        reset   = 1'b1;
  logic        cen     = 1'b0;
  logic [15:0] ram_addr;
  logic [7:0]  ram_wdata;
  logic        ram_we, ram_req;
  logic        ram_ack   = 1'b0;
  logic [7:0]  ram_rdata = 8'h00;
  logic [7:0]  doc_addr, doc_wdata;
  logic        doc_we, doc_strobe;
  logic [7:0]  doc_rdata = 8'h00;
  logic [3:0]  volume;

  sound_glu_if bus ();

  sound_glu #(.BASE(8'h3C), .RAM_AW(16)) dut (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .cen        (cen),
    .io         (bus),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_we     (ram_we),
    .ram_req    (ram_req),
    .ram_ack    (ram_ack),
    .ram_rdata  (ram_rdata),
    .doc_addr   (doc_addr),
    .doc_wdata  (doc_wdata),
    .doc_we     (doc_we),
    .doc_strobe (doc_strobe),
    .doc_rdata  (doc_rdata),
    .volume     (volume)
  );

  always #5 clk_sys = ~clk_sys;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Peripheral contents: one copy behind the DUT's pins, one owned by the model.
  logic [7:0] rmem_dut [65536];
  logic [7:0] rmem_mdl [65536];
  logic [7:0] dmem_dut [256];
  logic [7:0] dmem_mdl [256];

  bit         ack_allow = 1'b1, ack_rand = 1'b0, cen_rand = 1'b0;
  bit         doc_seen = 1'b0, doc_seen_we = 1'b0;
  logic [7:0] doc_seen_addr = 8'h00, doc_seen_data = 8'h00;

  // One clk_sys cycle: peripherals answer, then the CPU-side inputs for this cycle are applied.
  task automatic step(input bit s, input logic [7:0] a, input bit r, input logic [7:0] d);
    @(posedge clk_sys);
    #1;
    if (doc_seen) begin
      if (doc_seen_we) dmem_dut[doc_seen_addr] = doc_seen_data;
      doc_rdata = dmem_dut[doc_seen_addr];
    end else begin
      doc_rdata = 8'($urandom);
    end
    bus.strobe = s;
    bus.addr   = a;
    bus.rw     = r;
    bus.din    = d;
    cen        = cen_rand ? 1'($urandom) : 1'b1;
    ram_ack    = ram_req && ack_allow && (!ack_rand || ($urandom_range(0, 2) == 0));
    if (ram_ack) begin
      ram_rdata = rmem_dut[ram_addr];
      if (ram_we) rmem_dut[ram_addr] = ram_wdata;
    end else begin
      ram_rdata = 8'($urandom);
    end
    #2;
    doc_seen      = doc_strobe;
    doc_seen_we   = doc_we;
    doc_seen_addr = doc_addr;
    doc_seen_data = doc_wdata;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b1, 8'h00);
  endtask

  // Model: registers plus one outstanding transfer, described by whether it has been issued yet.
  logic [7:0]  m_ctl = 8'h00, m_latch = 8'h00, m_xdata = 8'h00;
  logic [15:0] m_adr = 16'h0000, m_xaddr = 16'h0000;
  bit          m_busy = 1'b0, m_sent = 1'b0, m_ram = 1'b0, m_wr = 1'b0;

  always @(negedge clk_sys) begin : compare
    logic       hit, exp_req, exp_dstb, done, acc;
    logic [7:0] exp_dout;
    if (reset) begin
      m_ctl = 8'h00; m_adr = 16'h0000; m_latch = 8'h00; m_busy = 1'b0; m_sent = 1'b0;
      check("reset_outputs", 32'({ram_req, ram_we, doc_strobe, doc_we, volume, bus.dout}), 32'h0);
    end else begin
      hit      = (bus.addr[7:2] == 6'h0F);
      exp_req  = m_busy && m_ram && m_sent;
      exp_dstb = m_busy && !m_ram && !m_sent && cen;
      exp_dout = 8'h00;
      if (bus.strobe && hit) begin
        case (bus.addr[1:0])
          2'd0:    exp_dout = {BUSY_BIT_EN & m_busy, m_ctl[6:0]};
          2'd1:    exp_dout = m_latch;
          2'd2:    exp_dout = m_adr[7:0];
          default: exp_dout = m_adr[15:8];
        endcase
      end
      check("dout", 32'(bus.dout), 32'(exp_dout));
      check("ram_req_we", 32'({ram_req, ram_we}), 32'({exp_req, exp_req && m_wr}));
      if (exp_req) check("ram_addr_wdata", 32'({ram_addr, ram_wdata}), 32'({m_xaddr, m_xdata}));
      check("doc_strobe_we", 32'({doc_strobe, doc_we}), 32'({exp_dstb, exp_dstb && m_wr}));
      if (exp_dstb) check("doc_addr_wdata", 32'({doc_addr, doc_wdata}), 32'({m_xaddr[7:0], m_xdata}));
      check("volume", 32'(volume), 32'(m_ctl[3:0]));

      // Advance to what the coming edge must produce.
      done = (exp_req && ram_ack) || (m_busy && !m_ram && m_sent);
      acc  = bus.strobe && hit && (bus.addr[1:0] == 2'd1) && !m_busy;
      if (done) begin
        if (m_wr) begin
          if (m_ram) rmem_mdl[m_xaddr] = m_xdata;
          else       dmem_mdl[m_xaddr[7:0]] = m_xdata;
        end else begin
          m_latch = m_ram ? rmem_mdl[m_xaddr] : dmem_mdl[m_xaddr[7:0]];
        end
        m_busy = 1'b0;
      end else if (m_busy && cen) begin
        m_sent = 1'b1;
      end
      if (acc) begin
        m_busy  = 1'b1;
        m_sent  = 1'b0;
        m_ram   = m_ctl[6];
        m_wr    = !bus.rw;
        m_xaddr = m_adr;
        m_xdata = bus.din;
        if (m_ctl[5]) m_adr = m_adr + 16'd1;
      end
      if (bus.strobe && hit && !bus.rw) begin
        case (bus.addr[1:0])
          2'd0:    m_ctl = bus.din & 8'h6F;
          2'd2:    m_adr[7:0] = bus.din;
          2'd3:    m_adr[15:8] = bus.din;
          default: ;
        endcase
      end
    end
  end

  initial begin
    bus.strobe = 1'b0;
    bus.addr   = 8'h00;
    bus.rw     = 1'b1;
    bus.din    = 8'h00;
    for (int i = 0; i < 65536; i++) begin
      rmem_dut[i] = 8'($urandom);
      rmem_mdl[i] = rmem_dut[i];
    end
    for (int i = 0; i < 256; i++) begin
      dmem_dut[i] = 8'($urandom);
      dmem_mdl[i] = dmem_dut[i];
    end
    rmem_dut[16'hFFFF] = 8'h11;
    rmem_mdl[16'hFFFF] = 8'h11;
    repeat (3) @(negedge clk_sys);
    #1 reset = 1'b0;

    // Reset state of the readable registers.
    step(1'b1, 8'h3C, 1'b1, 8'h00); check("t1_ctl", 32'(bus.dout), 32'h00);
    step(1'b1, 8'h3E, 1'b1, 8'h00); check("t1_adrl", 32'(bus.dout), 32'h00);
    step(1'b1, 8'h3F, 1'b1, 8'h00); check("t1_adrh", 32'(bus.dout), 32'h00);
    check("t1_req_dstb", 32'({ram_req, doc_strobe}), 32'h0);

    // RAM store with autoinc, ack withheld; a second SOUNDDATA write meanwhile is dropped.
    step(1'b1, 8'h3C, 1'b0, 8'h60);
    step(1'b1, 8'h3E, 1'b0, 8'h34);
    step(1'b1, 8'h3F, 1'b0, 8'h12);
    ack_allow = 1'b0;
    step(1'b1, 8'h3D, 1'b0, 8'hA5);
    idle(2);
    check("t2_req_we", 32'({ram_req, ram_we}), 32'h3);
    check("t2_ram_addr", 32'(ram_addr), 32'h1234);
    check("t2_ram_wdata", 32'(ram_wdata), 32'hA5);
    step(1'b1, 8'h3D, 1'b0, 8'h99);
    step(1'b1, 8'h3C, 1'b1, 8'h00); check("t5_busy_bit", 32'(bus.dout), BUSY_BIT_EN ? 32'hE0 : 32'h60);
    step(1'b1, 8'h3E, 1'b1, 8'h00); check("t5_adr_held", 32'(bus.dout), 32'h35);
    ack_allow = 1'b1;
    idle(1);
    idle(1); check("t2_req_drop", 32'(ram_req), 32'h0);
    idle(3); check("t5_no_second_req", 32'(ram_req), 32'h0);
    check("t2_ram_written", 32'(rmem_dut[16'h1234]), 32'hA5);
    step(1'b1, 8'h3F, 1'b1, 8'h00); check("t2_adrh", 32'(bus.dout), 32'h12);

    // Dummy-read semantics at FFFF without autoinc.
    step(1'b1, 8'h3C, 1'b0, 8'h40);
    step(1'b1, 8'h3E, 1'b0, 8'hFF);
    step(1'b1, 8'h3F, 1'b0, 8'hFF);
    step(1'b1, 8'h3D, 1'b1, 8'h00); check("t3_stale", 32'(bus.dout), 32'h00);
    idle(6);
    step(1'b1, 8'h3D, 1'b1, 8'h00); check("t3_fetched", 32'(bus.dout), 32'h11);
    step(1'b1, 8'h3E, 1'b1, 8'h00); check("t3_adrl", 32'(bus.dout), 32'hFF);
    step(1'b1, 8'h3F, 1'b1, 8'h00); check("t3_adrh", 32'(bus.dout), 32'hFF);
    idle(6);

    // DOC store; the autoinc carries into the high byte.
    step(1'b1, 8'h3C, 1'b0, 8'h20);
    step(1'b1, 8'h3E, 1'b0, 8'hFF);
    step(1'b1, 8'h3F, 1'b0, 8'h00);
    step(1'b1, 8'h3D, 1'b0, 8'h7E);
    idle(1);
    check("t4_dstb_we", 32'({doc_strobe, doc_we}), 32'h3);
    check("t4_doc_addr", 32'(doc_addr), 32'hFF);
    check("t4_doc_wdata", 32'(doc_wdata), 32'h7E);
    idle(1); check("t4_dstb_pulse", 32'(doc_strobe), 32'h0);
    idle(1);
    step(1'b1, 8'h3E, 1'b1, 8'h00); check("t4_adrl", 32'(bus.dout), 32'h00);
    step(1'b1, 8'h3F, 1'b1, 8'h00); check("t4_adrh", 32'(bus.dout), 32'h01);

    // Outside the decode window.
    step(1'b1, 8'h40, 1'b1, 8'h00); check("win_40", 32'(bus.dout), 32'h00);
    step(1'b1, 8'h3B, 1'b1, 8'h00); check("win_3b", 32'(bus.dout), 32'h00);

    // Asynchronous reset with a RAM request outstanding.
    step(1'b1, 8'h3C, 1'b0, 8'h4F);
    ack_allow = 1'b0;
    step(1'b1, 8'h3D, 1'b0, 8'hC3);
    idle(2);
    check("t6_req_before", 32'(ram_req), 32'h1);
    bus.strobe = 1'b0;
    reset = 1'b1;
    #1 check("t6_req_async", 32'(ram_req), 32'h0);
    repeat (2) @(negedge clk_sys);
    #1 reset = 1'b0;
    ack_allow = 1'b1;
    step(1'b1, 8'h3C, 1'b1, 8'h00); check("t6_ctl", 32'(bus.dout), 32'h00);
    check("t6_volume", 32'(volume), 32'h0);
    step(1'b1, 8'h3E, 1'b1, 8'h00); check("t6_adrl", 32'(bus.dout), 32'h00);
    step(1'b1, 8'h3F, 1'b1, 8'h00); check("t6_adrh", 32'(bus.dout), 32'h00);
    idle(2);

    // Random traffic against the model.
    cen_rand = 1'b1;
    ack_rand = 1'b1;
    for (int n = 0; n < 4000; n++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r <= 3)      step(1'b1, 8'h3D, 1'($urandom), 8'($urandom));
      else if (r == 4) step(1'b1, 8'h3C, 1'($urandom), 8'($urandom));
      else if (r == 5) step(1'b1, 8'h3E + 8'($urandom_range(0, 1)), 1'($urandom), 8'($urandom));
      else if (r == 6) step(1'b1, 8'($urandom), 1'($urandom), 8'($urandom));
      else             step(1'b0, 8'($urandom), 1'($urandom), 8'($urandom));
    end
    idle(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
